// File: rtl/note_frame_serializer.sv
// Framed serial transmitter for the note-activity vector: one bit slot every
// CLKS_PER_BIT clocks, optional even-parity slot, sync high in the last slot.
module note_frame_serializer #(
  parameter int NUM_NOTES    = 48,
  parameter int CLKS_PER_BIT = 8192,
  parameter int FRAME_SLOTS  = 64,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] active,
  output logic                 note_serial_sync,
  output logic                 note_serial_data,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int DIV_W  = $clog2(CLKS_PER_BIT);
  localparam int SLOT_W = $clog2(FRAME_SLOTS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [SLOT_W-1:0] DATA_END  = SLOT_W'(NUM_NOTES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(FRAME_SLOTS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [SLOT_W-1:0]    slot;
  logic [NUM_NOTES-1:0] shadow;
  logic [NUM_NOTES-1:0] shadow_shift;
  logic                 send_bit;
  logic                 tick;

  assign tick = (div_cnt == '0);

  // Bit for the slot about to begin; slots past data and parity carry 0.
  always_comb begin
    shadow_shift = shadow >> slot;
    send_bit     = 1'b0;
    if (slot < DATA_END) begin
      send_bit = shadow_shift[0];
    end else if ((PARITY_EN != 0) && (slot == DATA_END)) begin
      send_bit = ^shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      div_cnt          <= '0;
      slot             <= '0;
      shadow           <= '0;
      note_serial_sync <= 1'b0;
      note_serial_data <= 1'b0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (tick) begin
        // Idle ticks and the tick after the last slot are frame-start decisions.
        if ((state == IDLE) || (slot == SLOT_END)) begin
          if (enable) begin
            state            <= SEND;
            shadow           <= active;
            note_serial_data <= active[0];
            note_serial_sync <= 1'b0;
            slot             <= SLOT_W'(1);
            busy             <= 1'b1;
            frame_start      <= 1'b1;
          end else begin
            state            <= IDLE;
            note_serial_data <= 1'b0;
            note_serial_sync <= 1'b0;
            slot             <= '0;
            busy             <= 1'b0;
          end
        end else begin
          note_serial_data <= send_bit;
          note_serial_sync <= (slot == SLOT_LAST);
          frame_done       <= (slot == SLOT_LAST);
          slot             <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_frame_serializer.sv
// Directed bench for note_frame_serializer: a parity and a no-parity instance
// share stimulus; a monitor captures each frame and compares against exp_q.
module tb_note_frame_serializer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] active;

  logic sync1, data1, fs1, fd1, busy1;
  logic sync0, data0, fs0, fd0, busy0;

  int n_vec;
  int n_bad;

  // {parity-on data word, parity-off data word}; bit k is slot k.
  logic [23:0] exp_q[$];

  note_frame_serializer #(
    .NUM_NOTES(8), .CLKS_PER_BIT(4), .FRAME_SLOTS(12), .PARITY_EN(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .active(active),
    .note_serial_sync(sync1), .note_serial_data(data1),
    .frame_start(fs1), .frame_done(fd1), .busy(busy1)
  );

  note_frame_serializer #(
    .NUM_NOTES(8), .CLKS_PER_BIT(4), .FRAME_SLOTS(12), .PARITY_EN(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .active(active),
    .note_serial_sync(sync0), .note_serial_data(data0),
    .frame_start(fs0), .frame_done(fd0), .busy(busy0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {busy1, data1, sync1, fs1, fd1, busy0, data0, sync0, fs0, fd0};
  endfunction

  // driver tasks
  task automatic wait_start();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs1 && k < 200);
    check("frame_start_timeout", 32'(fs1), 32'd1);
  endtask

  // Run one frame and return at slot 11, cycle 0.
  task automatic run_frame(input logic [7:0] a, input logic [11:0] e1, input logic [11:0] e0,
                           input int chg_slot, input logic [7:0] chg_val, input int drop_slot);
    active = a;
    exp_q.push_back({e1, e0});
    wait_start();
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i == chg_slot * 4 + 1) active = chg_val;
      if (i == drop_slot * 4 + 1) enable = 1'b0;
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [11:0] d1, d0, s1, s0;
    logic [23:0] e;
    int          sync_cnt, done_cnt, done_idx, fs_cnt;
    logic        busy_bad, stable_bad, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && fs1) begin
        d1 = '0; d0 = '0; s1 = '0; s0 = '0;
        sync_cnt = 0; done_cnt = 0; done_idx = -1; fs_cnt = 0;
        busy_bad = 1'b0; stable_bad = 1'b0; aborted = 1'b0;
        for (int n = 0; n < 48; n++) begin
          if (n > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (n % 4 == 1) begin
            d1[n/4] = data1; d0[n/4] = data0;
            s1[n/4] = sync1; s0[n/4] = sync0;
          end
          if (n % 4 == 3 && (data1 !== d1[n/4] || data0 !== d0[n/4])) stable_bad = 1'b1;
          if (sync1) sync_cnt++;
          if (fd1) begin
            done_cnt++;
            done_idx = n;
          end
          if (fs1) fs_cnt++;
          if (!busy1 || !busy0) busy_bad = 1'b1;
        end
        if (!aborted) begin
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_parity_on", 32'(d1), 32'(e[23:12]));
            check("data_parity_off", 32'(d0), 32'(e[11:0]));
            check("sync_slots_on", 32'(s1), 32'h800);
            check("sync_slots_off", 32'(s0), 32'h800);
            check("sync_clks", 32'(sync_cnt), 32'd4);
            check("frame_done_count", 32'(done_cnt), 32'd1);
            check("frame_done_pos", 32'(done_idx), 32'd44);
            check("frame_start_count", 32'(fs_cnt), 32'd1);
            check("busy_in_frame", 32'(busy_bad), 32'd0);
            check("data_stable", 32'(stable_bad), 32'd0);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [9:0] seen;
    int         k;
    n_vec  = 0;
    n_bad  = 0;
    rst_n  = 1'b1;
    enable = 1'b0;
    active = 8'hA5;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;

    // enable low from reset: nothing moves
    seen = '0;
    repeat (200) begin
      @(negedge clk);
      seen = seen | all_outs();
    end
    check("idle_quiet", 32'(seen), 32'd0);

    enable = 1'b1;
    run_frame(8'hA5, 12'h0A5, 12'h0A5, -1, 8'h00, -1);
    run_frame(8'h07, 12'h107, 12'h007, -1, 8'h00, -1);
    run_frame(8'h00, 12'h000, 12'h000, -1, 8'h00, -1);
    run_frame(8'hFF, 12'h0FF, 12'h0FF, 2, 8'h00, -1);
    run_frame(8'h00, 12'h000, 12'h000, -1, 8'h00, -1);
    // enable dropped in slot 4: frame still completes
    run_frame(8'h5A, 12'h05A, 12'h05A, -1, 8'h00, 4);
    seen = '0;
    for (int i = 1; i <= 104; i++) begin
      @(negedge clk);
      if (i >= 4) seen = seen | all_outs();
    end
    check("gated_idle", 32'(seen), 32'd0);

    // reset during slot 5 aborts at once
    active = 8'h3C;
    enable = 1'b1;
    wait_start();
    repeat (21) @(negedge clk);
    check("busy_before_reset", 32'(busy1), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(all_outs()), 32'd0);
    active = 8'h83;
    exp_q.push_back({12'h183, 12'h083});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_start", 32'({fs1, data1, busy1}), 32'b111);
    enable = 1'b0;
    repeat (60) @(negedge clk);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(all_outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
